// File: rtl/alu_sequencer.sv
// Command sequencer for the switch-driven calculator: owns the A/B/Y registers and drives the external ALU mux.
// Optional accumulator mode (CAPTURE also loads A with the ALU result) is enabled by defining ALU_SEQ_ACCUM_EN.
module alu_sequencer #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] din,
    output logic [3:0]       alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    output logic [WIDTH-1:0] reg_a,
    output logic [WIDTH-1:0] reg_b,
    output logic [WIDTH-1:0] reg_y,
    output logic             done,
    output logic             busy
);

    localparam logic [1:0] CMD_LOAD_A = 2'b00;
    localparam logic [1:0] CMD_LOAD_B = 2'b01;
    localparam logic [1:0] CMD_EXEC   = 2'b10;
    localparam logic [1:0] CMD_CLEAR  = 2'b11;
    localparam logic [3:0] OP_NEG     = 4'hC;
    localparam logic [3:0] OP_STO     = 4'hD;
    localparam logic [3:0] OP_SWP     = 4'hE;
    localparam logic [3:0] OP_LOAD    = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_CAPTURE = 3'd2,
        S_WB      = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic [3:0]       sel_q, sel_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    // Next-state, register-file and status decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        op_d    = op_q;
        din_d   = din_q;
        sel_d   = sel_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cmd_d = cmd;
                    op_d  = op;
                    din_d = din;
                    if ((cmd == CMD_EXEC) && (op <= OP_NEG)) begin
                        state_d = S_SETTLE;
                        cnt_d   = 4'(SETTLE - 1);
                        sel_d   = op;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_CAPTURE: begin
                y_d = alu_y;
`ifdef ALU_SEQ_ACCUM_EN
                a_d = alu_y;
`endif
                state_d = S_DONE;
            end
            S_WB: begin
                case (cmd_q)
                    CMD_LOAD_A: a_d = din_q;
                    CMD_LOAD_B: b_d = din_q;
                    CMD_CLEAR: begin
                        a_d = '0;
                        b_d = '0;
                        y_d = '0;
                    end
                    CMD_EXEC: begin
                        case (op_q)
                            OP_STO:  a_d = y_q;
                            OP_SWP: begin
                                a_d = b_q;
                                b_d = a_q;
                            end
                            OP_LOAD: a_d = din_q;
                            default: a_d = a_q;
                        endcase
                    end
                    default: a_d = a_q;
                endcase
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Status flags are registered from the next state so they align with it
        done_d  = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers with asynchronous abort
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            cmd_q   <= 2'b00;
            op_q    <= 4'd0;
            din_q   <= '0;
            sel_q   <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            op_q    <= op_d;
            din_q   <= din_d;
            sel_q   <= sel_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign cmd_ready = ready_q;
    assign alu_sel   = sel_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign reg_a     = a_q;
    assign reg_b     = b_q;
    assign reg_y     = y_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule
